// File: rtl/imem_loader_if.sv
// Host-link byte stream, load control and instruction-memory write port of imem_loader.
// Latency: none, signal bundle only.
// Backpressure: byte_valid/byte_ready handshake; the memory write port has no backpressure.
//
// Ports (slave = loader side):
//   load_req/load_len/halt        in   load control from the host
//   byte_data/byte_valid          in   big-endian byte stream
//   byte_ready                    out  loader takes a byte on this edge
//   ext_instr/_addr/_en           out  one-cycle word write into instruction memory
//   start/load_err/words_loaded   out  run enable and load status
interface imem_loader_if;
    logic        load_req;
    logic [7:0]  load_len;
    logic        halt;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] ext_instr;
    logic [31:0] ext_instr_addr;
    logic        ext_instr_en;
    logic        start;
    logic        load_err;
    logic [7:0]  words_loaded;

    modport master (
        output load_req, load_len, halt, byte_data, byte_valid,
        input  byte_ready, ext_instr, ext_instr_addr, ext_instr_en,
        input  start, load_err, words_loaded
    );

    modport slave (
        input  load_req, load_len, halt, byte_data, byte_valid,
        output byte_ready, ext_instr, ext_instr_addr, ext_instr_en,
        output start, load_err, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words, writes them to imem, then raises start.
// Latency: 4th byte accepted at edge N -> write strobe in cycle N..N+1; start one cycle after the last strobe.
// Backpressure: byte_ready is registered, high only in RECV; it drops for the one WRITE cycle per word.
//
// Ports:
//   clk    in  clock, all state changes on the rising edge
//   rst_n  in  asynchronous active-low reset; every output clears immediately
//   bus    imem_loader_if.slave (load control, byte stream, memory write port, status)
module imem_loader #(
    parameter int MEM_BYTES = 256,
    parameter int TIMEOUT   = 65535
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam int TW = $clog2(TIMEOUT + 1);
    // load_len == 0 means the whole memory; for a 1 KiB memory this truncates to 0,
    // which still matches because the 8-bit word counter wraps to 0 on the 256th word.
    localparam logic [7:0] FULL_LEN = 8'(MEM_BYTES / 4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q;
    logic [7:0]      len_q;
    logic [7:0]      cnt_q;
    logic [1:0]      idx_q;
    logic [TW-1:0]   tmo_q;
    logic [31:0]     word_q;
    logic            byte_ready_q;
    logic            en_q;
    logic            start_q;
    logic            err_q;

    logic            accept;
    logic            tmo_hit;
    logic            load_go;
    logic            write_done;

    // halt wins over everything, so a byte presented while halting is not taken
    assign accept     = (state_q == ST_RECV) && byte_ready_q && bus.byte_valid && !bus.halt;
    assign load_go    = !bus.halt && bus.load_req && (state_q == ST_IDLE || state_q == ST_RUN);
    assign write_done = (state_q == ST_WRITE) && !bus.halt;

    always_comb begin
        state_d = state_q;
        tmo_hit = 1'b0;
        if (bus.halt) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.load_req) state_d = ST_RECV;
                end
                ST_RECV: begin
                    if (accept) begin
                        if (idx_q == 2'd3) state_d = ST_WRITE;
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        // this idle cycle is the TIMEOUT-th in a row
                        tmo_hit = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    state_d = ((cnt_q + 8'd1) == len_q) ? ST_RUN : ST_RECV;
                end
                ST_RUN: begin
                    if (bus.load_req) state_d = ST_RECV;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            tmo_q        <= '0;
            word_q       <= '0;
            byte_ready_q <= 1'b0;
            en_q         <= 1'b0;
            start_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // registered outputs follow the state being entered
            byte_ready_q <= (state_d == ST_RECV);
            en_q         <= (state_d == ST_WRITE);
            start_q      <= (state_d == ST_RUN);

            if (load_go) begin
                len_q  <= (bus.load_len == 8'd0) ? FULL_LEN : bus.load_len;
                addr_q <= '0;
                cnt_q  <= '0;
                idx_q  <= '0;
                tmo_q  <= '0;
                err_q  <= 1'b0;
            end

            if (accept) begin
                case (idx_q)
                    2'd0:    word_q[31:24] <= bus.byte_data;
                    2'd1:    word_q[23:16] <= bus.byte_data;
                    2'd2:    word_q[15:8]  <= bus.byte_data;
                    default: word_q[7:0]   <= bus.byte_data;
                endcase
                idx_q <= idx_q + 2'd1;
                tmo_q <= '0;
            end else if (state_q == ST_RECV && !bus.halt) begin
                tmo_q <= tmo_q + TW'(1);
            end

            if (tmo_hit) begin
                err_q <= 1'b1;
            end

            // a halted WRITE still strobes, but the word is not counted
            if (write_done) begin
                addr_q <= addr_q + AW'(4);
                cnt_q  <= cnt_q + 8'd1;
                idx_q  <= '0;
            end
        end
    end

    assign bus.byte_ready     = byte_ready_q;
    assign bus.ext_instr      = word_q;
    assign bus.ext_instr_addr = {{(32 - AW){1'b0}}, addr_q};
    assign bus.ext_instr_en   = en_q;
    assign bus.start          = start_q;
    assign bus.load_err       = err_q;
    assign bus.words_loaded   = cnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random byte streams against a word-packing reference model.
// Latency: checks strobe-to-start spacing, timeout boundary and async reset behaviour.
// Backpressure: byte driver holds byte_valid until byte_ready is seen, with random idle gaps.
module tb_imem_loader;
    localparam int MEM_BYTES = 256;
    localparam int TIMEOUT   = 8;

    typedef logic [7:0] byte_q_t [$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if bus ();

    imem_loader #(
        .MEM_BYTES (MEM_BYTES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // monitor state
    int          cyc = 0;
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          last_wr_cyc    = -1;
    int          start_rise_cyc = -1;
    logic        start_prev     = 1'b0;
    int          acc_cnt        = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (bus.ext_instr_en) begin
                wr_addr_q.push_back(bus.ext_instr_addr);
                wr_data_q.push_back(bus.ext_instr);
                last_wr_cyc = cyc;
            end
            if (bus.start && !start_prev && start_rise_cyc < 0) start_rise_cyc = cyc;
            start_prev = bus.start;
            if (bus.byte_valid && bus.byte_ready) acc_cnt = acc_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        last_wr_cyc    = -1;
        start_rise_cyc = -1;
        acc_cnt        = 0;
    endtask

    task automatic start_load(input logic [7:0] len);
        bus.load_len = len;
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
    endtask

    // present one byte after a random idle gap and hold it until it is taken
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int g;
        bit done;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (g) tick();
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = bus.byte_ready;
            @(posedge clk);
            #1;
        end
        bus.byte_valid = 1'b0;
        if (!done) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_stream(input byte_q_t bytes, input int max_gap);
        foreach (bytes[i]) send_byte(bytes[i], max_gap);
    endtask

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255, 0)));
        return q;
    endfunction

    // reference: every complete group of 4 bytes is one word, MSB first, at byte address 4*i
    task automatic check_writes(input string tag, input byte_q_t bytes);
        int nw;
        logic [31:0] exp_w;
        logic [31:0] exp_a;
        nw = bytes.size() / 4;
        check($sformatf("%s_count", tag), 32'(wr_addr_q.size()), 32'(nw));
        for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
            exp_w = {bytes[4*i], bytes[4*i+1], bytes[4*i+2], bytes[4*i+3]};
            exp_a = 32'((4 * i) % MEM_BYTES);
            check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], exp_a);
            check($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_w);
        end
    endtask

    task automatic wait_start(input string tag, input int max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            seen = bus.start;
        end
        check($sformatf("%s_start_seen", tag), 32'(seen), 32'd1);
        check($sformatf("%s_start_after_last_write", tag), 32'(start_rise_cyc), 32'(last_wr_cyc + 1));
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s_byte_ready", tag), 32'(bus.byte_ready), 32'd0);
        check($sformatf("%s_start", tag), 32'(bus.start), 32'd0);
        check($sformatf("%s_en", tag), 32'(bus.ext_instr_en), 32'd0);
        check($sformatf("%s_instr", tag), bus.ext_instr, 32'd0);
        check($sformatf("%s_addr", tag), bus.ext_instr_addr, 32'd0);
        check($sformatf("%s_err", tag), 32'(bus.load_err), 32'd0);
        check($sformatf("%s_words", tag), 32'(bus.words_loaded), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t b;
        bus.load_req   = 1'b0;
        bus.load_len   = 8'd0;
        bus.halt       = 1'b0;
        bus.byte_data  = 8'd0;
        bus.byte_valid = 1'b0;

        // reset state
        #12;
        check_all_zero("rst");
        rst_n = 1'b1;
        tick();
        check_all_zero("idle");

        // two words back-to-back, fixed pattern
        clear_mon();
        b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        start_load(8'd2);
        check("t1_ready_after_req", 32'(bus.byte_ready), 32'd1);
        send_stream(b, 0);
        wait_start("t1", 10);
        check_writes("t1", b);
        check("t1_words", 32'(bus.words_loaded), 32'd2);

        // reload from RUN with one word
        clear_mon();
        start_load(8'd1);
        check("rl_start_drop", 32'(bus.start), 32'd0);
        check("rl_ready", 32'(bus.byte_ready), 32'd1);
        check("rl_words_clr", 32'(bus.words_loaded), 32'd0);
        b = rand_bytes(4);
        send_stream(b, 2);
        wait_start("rl", 10);
        check_writes("rl", b);
        check("rl_words", 32'(bus.words_loaded), 32'd1);

        // full memory, random gaps shorter than the timeout
        clear_mon();
        start_load(8'd0);
        b = rand_bytes(MEM_BYTES);
        send_stream(b, 3);
        wait_start("full", 20);
        check_writes("full", b);
        if (wr_addr_q.size() > 0)
            check("full_last_addr", wr_addr_q[wr_addr_q.size()-1], 32'(MEM_BYTES - 4));
        check("full_words", 32'(bus.words_loaded), 32'(MEM_BYTES / 4));
        check("full_accepts", 32'(acc_cnt), 32'(MEM_BYTES));

        // timeout: 2 bytes then silence
        clear_mon();
        start_load(8'd1);
        b = rand_bytes(2);
        send_stream(b, 0);
        repeat (TIMEOUT - 1) tick();
        check("tmo_err_early", 32'(bus.load_err), 32'd0);
        check("tmo_ready_early", 32'(bus.byte_ready), 32'd1);
        tick();
        check("tmo_err", 32'(bus.load_err), 32'd1);
        check("tmo_ready", 32'(bus.byte_ready), 32'd0);
        check("tmo_no_write", 32'(wr_addr_q.size()), 32'd0);
        bus.byte_valid = 1'b1;
        repeat (3) tick();
        bus.byte_valid = 1'b0;
        check("tmo_no_consume", 32'(acc_cnt), 32'd2);
        start_load(8'd1);
        check("tmo_err_clr", 32'(bus.load_err), 32'd0);
        check("tmo_reload_ready", 32'(bus.byte_ready), 32'd1);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;

        // halt after 6 bytes of a 3-word load
        clear_mon();
        start_load(8'd3);
        b = rand_bytes(6);
        send_stream(b, 2);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        check("halt_ready", 32'(bus.byte_ready), 32'd0);
        check("halt_start", 32'(bus.start), 32'd0);
        check("halt_words", 32'(bus.words_loaded), 32'd1);
        bus.byte_valid = 1'b1;
        repeat (4) tick();
        bus.byte_valid = 1'b0;
        check("halt_no_consume", 32'(acc_cnt), 32'd6);
        check_writes("halt", b);

        // halt landing on the WRITE cycle: strobe still happens, word not counted
        clear_mon();
        start_load(8'd2);
        b = rand_bytes(4);
        send_stream(b, 0);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        tick();
        check_writes("hw", b);
        check("hw_words", 32'(bus.words_loaded), 32'd0);
        check("hw_ready", 32'(bus.byte_ready), 32'd0);

        // asynchronous reset in the middle of RECV
        clear_mon();
        start_load(8'd2);
        b = rand_bytes(5);
        send_stream(b, 0);
        check("ar_pre_words", 32'(bus.words_loaded), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("ar");
        #10;
        rst_n = 1'b1;
        tick();
        check("ar_idle_ready", 32'(bus.byte_ready), 32'd0);
        check("ar_idle_start", 32'(bus.start), 32'd0);
        acc_cnt = 0;
        bus.byte_valid = 1'b1;
        repeat (3) tick();
        bus.byte_valid = 1'b0;
        check("ar_no_consume", 32'(acc_cnt), 32'd0);
        start_load(8'd1);
        check("ar_reload_ready", 32'(bus.byte_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
